// File: rtl/otter_fetch_unit.sv
// OTTER instruction fetch unit: sequential fetch into a credit-limited
// instruction queue that feeds decode; a redirect flushes the queue and refetches.
module otter_fetch_unit #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int          DEPTH     = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [31:0] IMEM_ADDR,
    output logic        IMEM_READ,
    input  logic [31:0] IMEM_DOUT,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        DE_VALID,
    input  logic        DE_READY,
    output logic [31:0] DE_PC,
    output logic [31:0] DE_IR
);
    localparam int            PW   = $clog2(DEPTH);
    localparam int            CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   r_fpc;
    logic [31:0]   r_ifl_pc;
    logic          r_ifl;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_pc_q [DEPTH];
    logic [31:0]   r_ir_q [DEPTH];

    logic [31:0]   w_redir_addr;
    logic [CW-1:0] w_occ;
    logic          w_pop;
    logic          w_push;
    logic          w_issue;
    logic          w_unused;

    assign w_redir_addr = {REDIRECT_PC[31:2], 2'b00};
    assign w_unused     = ^REDIRECT_PC[1:0];

    // Occupancy counts the word still in flight, so a full queue never overflows.
    assign w_occ    = r_count + CW'(r_ifl);
    assign DE_VALID = (r_count != '0);
    assign DE_PC    = r_pc_q[r_rd_ptr];
    assign DE_IR    = r_ir_q[r_rd_ptr];
    assign w_pop    = DE_VALID & DE_READY & ~REDIRECT;
    assign w_push   = r_ifl & ~REDIRECT;
    assign w_issue  = (w_occ < FULL) | ((w_occ == FULL) & w_pop);

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        IMEM_READ = 1'b0;
        IMEM_ADDR = r_fpc;
        if (!RESET) begin
            if (REDIRECT) begin
                IMEM_READ = 1'b1;
                IMEM_ADDR = w_redir_addr;
            end else begin
                IMEM_READ = w_issue;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_fpc    <= RESET_VEC;
            r_ifl    <= 1'b0;
            r_ifl_pc <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (REDIRECT) begin
            r_fpc    <= w_redir_addr + 32'd4;
            r_ifl    <= 1'b1;
            r_ifl_pc <= w_redir_addr;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_issue) begin
                r_fpc    <= r_fpc + 32'd4;
                r_ifl    <= 1'b1;
                r_ifl_pc <= r_fpc;
            end else begin
                r_ifl <= 1'b0;
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: queue storage is reset so the head reads as zero while RESET is held.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_q[i] <= '0;
                r_ir_q[i] <= '0;
            end
        end else if (w_push) begin
            r_pc_q[r_wr_ptr] <= r_ifl_pc;
            r_ir_q[r_wr_ptr] <= IMEM_DOUT;
        end
    end

endmodule

// File: doc/otter_fetch_unit.md
OTTER_FETCH_UNIT -- requirements
Module: otter_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_VEC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4, instruction-queue entries; power of two, minimum 2.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port RESET  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port IMEM_ADDR  output  32  fetch address to instruction memory port 1.
REQ-006 SHALL have port IMEM_READ  output  1  fetch strobe; memory samples IMEM_ADDR on the edge where this is high.
REQ-007 SHALL have port IMEM_DOUT  input  32  instruction word, valid exactly one cycle after the sampling edge.
REQ-008 SHALL have port REDIRECT  input  1  taken branch or jump from execute; flush and refetch.
REQ-009 SHALL have port REDIRECT_PC  input  32  redirect target.
REQ-010 SHALL have port DE_VALID  output  1  queue head holds a valid instruction for decode.
REQ-011 SHALL have port DE_READY  input  1  decode accepts the head this cycle.
REQ-012 SHALL have port DE_PC  output  32  PC of the queue head.
REQ-013 SHALL have port DE_IR  output  32  instruction word of the queue head.

Function
REQ-014 SHALL hold a fetch PC register (fpc), a one-deep in-flight flag (ifl) with its PC (ifl_pc), and a DEPTH-entry FIFO of {pc, ir} with an occupancy count.
REQ-015 SHALL define pop = DE_VALID & DE_READY & !REDIRECT, and issue = (count + ifl < DEPTH) | (count + ifl == DEPTH & pop).
REQ-016 SHALL, when issuing without a redirect, drive IMEM_READ=1 and IMEM_ADDR=fpc, then set fpc<=fpc+4, ifl<=1, ifl_pc<=fpc.
REQ-017 SHALL, when not issuing, drive IMEM_READ=0 and clear ifl at the edge.
REQ-018 SHALL, in the cycle after a sampled fetch with ifl=1 and no REDIRECT, push {ifl_pc, IMEM_DOUT} at the FIFO tail.
REQ-019 SHALL drive DE_VALID=(count!=0) and DE_PC/DE_IR from the FIFO head only, registered with no memory-to-decode bypass; latency from issue to DE_VALID is 2 cycles.
REQ-020 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers; the credit rule in REQ-015 makes overflow impossible.
REQ-021 SHALL sustain one instruction per cycle while DE_READY stays high and REDIRECT stays low.
REQ-022 SHALL, while DE_READY is low, hold DE_PC/DE_IR stable and stop issuing once count+ifl reaches DEPTH.
REQ-023 SHALL, in a REDIRECT=1 cycle:
  - empty the FIFO and discard any IMEM_DOUT arriving that cycle;
  - ignore DE_READY for that cycle;
  - drive IMEM_READ=1 and IMEM_ADDR={REDIRECT_PC[31:2],2'b00};
  - set fpc to that address +4, ifl<=1, ifl_pc to that address.
REQ-024 SHALL force REDIRECT_PC[1:0] to 00 before use.
REQ-025 SHALL wrap fpc modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-026 SHALL let a REDIRECT in the cycle after a previous REDIRECT take effect; the latest redirect wins, and no instruction from the earlier target reaches decode.
REQ-027 SHALL allow DE_VALID to be high in a REDIRECT cycle, but no pop occurs and no entry survives the edge.

Reset
REQ-028 SHALL, while RESET=1, immediately set fpc=RESET_VEC, count=0, ifl=0, both FIFO pointers=0, DE_VALID=0 and IMEM_READ=0.
REQ-029 SHALL hold DE_PC and DE_IR at 0 under reset.
REQ-030 SHALL issue RESET_VEC on the first edge after RESET deasserts; a reset asserted mid-operation discards all queued and in-flight instructions.

Verification
REQ-031 Cold start: DEPTH=4, RESET_VEC=0, DE_READY=1, memory returns ir=addr^32'hA5A5_0000 -> IMEM_ADDR 0,4,8 on consecutive cycles; DE_VALID rises 2 cycles after first issue with DE_PC=0; then one entry per cycle, PCs 0,4,8.
REQ-032 Backpressure: DE_READY=0 from start -> exactly 4 entries (PC 0x0-0xC) queued, IMEM_READ low, fpc=0x10; raising DE_READY yields 0x0,0x4,0x8,0xC,0x10 in order with no loss or duplication.
REQ-033 Redirect flush: 3 entries queued plus 1 in flight, REDIRECT=1 with REDIRECT_PC=0x100 -> IMEM_ADDR=0x100 that cycle; next DE_VALID shows DE_PC=0x100; no older PC appears afterwards.
REQ-034 Misaligned and wrap: REDIRECT_PC=0x103 -> fetch 0x100; REDIRECT_PC=0xFFFF_FFFC -> fetch sequence 0xFFFF_FFFC, 0x0000_0000.
REQ-035 Async reset mid-stream: RESET pulsed between edges with 2 entries queued -> DE_VALID and IMEM_READ drop before the next edge; after release the fetch restarts at RESET_VEC.
REQ-036 Back-to-back redirects: REDIRECT to 0x200 then to 0x300 on the next cycle -> first decoded PC is 0x300; 0x200 never appears on DE_PC.
